// File: rtl/button_pkg.sv
// Shared constants for the pushbutton conditioner: default sizing
// parameters, button index map and a small width helper.
package button_pkg;

  // Default sizing of the conditioner
  localparam int DIV_BITS_DEF   = 16;
  localparam int DB_DEPTH_DEF   = 8;
  localparam int LONG_TICKS_DEF = 256;

  // Bit positions of each button in the press_pulse vector
  localparam int BTN_EN    = 0;
  localparam int BTN_SPEED = 1;
  localparam int BTN_CLR   = 2;
  localparam int NUM_BTN   = 3;

  // Bits needed to count from 0 up to and including 'ticks'
  function automatic int hold_bits(input int ticks);
    return $clog2(ticks + 1);
  endfunction

endpackage

// File: rtl/debounce_onepulse.sv
// One button channel: 2-flop synchroniser, tick-sampled shift register,
// hysteretic debounced level and a rising-edge one-clock pulse.
module debounce_onepulse
  import button_pkg::*;
#(
  parameter int DB_DEPTH = DB_DEPTH_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_tick,
  input  logic i_btn,
  output logic o_db,
  output logic o_pulse
);

  logic [1:0]          r_sync;
  logic [DB_DEPTH-1:0] r_shift;
  logic [DB_DEPTH-1:0] w_shift_next;
  logic                r_db;
  logic                r_db_d;

  // Shift register contents once the current synchronised sample is taken
  assign w_shift_next = {r_shift[DB_DEPTH-2:0], r_sync[1]};

  // Bring the raw asynchronous button into the clk domain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= 2'b00;
    end else begin
      r_sync <= {r_sync[0], i_btn};
    end
  end

  // Sample on tick; the level follows the same edge that completes a full run
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift <= '0;
      r_db    <= 1'b0;
    end else if (i_tick) begin
      r_shift <= w_shift_next;
      if (&w_shift_next) begin
        r_db <= 1'b1;
      end else if (~|w_shift_next) begin
        r_db <= 1'b0;
      end
    end
  end

  // Delayed copy of the level for rising-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_db_d <= 1'b0;
    end else begin
      r_db_d <= r_db;
    end
  end

  // Press pulse is purely registered state, so it is glitch-free
  assign o_db    = r_db;
  assign o_pulse = r_db & ~r_db_d;

endmodule

// File: rtl/button_ctrl.sv
// Pushbutton conditioner for the LED pattern controllers: three debounced
// channels sharing one sample tick, plus run/speed toggle registers and a
// clear pulse. Optional long-press detection on the enable button is built
// when BUTTON_CTRL_LONG_PRESS_EN is defined.
module button_ctrl
  import button_pkg::*;
#(
  parameter int DIV_BITS   = DIV_BITS_DEF,
  parameter int DB_DEPTH   = DB_DEPTH_DEF,
  parameter int LONG_TICKS = LONG_TICKS_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_en,
  input  logic       btn_speed,
  input  logic       btn_clr,
  output logic       en,
  output logic       speed,
  output logic       clr_pulse,
  output logic [2:0] press_pulse,
  output logic       long_press
);

  logic [DIV_BITS-1:0] r_div;
  logic                w_tick;
  logic [NUM_BTN-1:0]  w_btn;
  logic [NUM_BTN-1:0]  w_db;
  logic [NUM_BTN-1:0]  w_pulse;
  logic                w_long;
  logic                r_en;
  logic                r_speed;
  logic                w_unused_db;

  // Free-running sample divider; tick marks the all-ones count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  assign w_tick = &r_div;

  assign w_btn[BTN_EN]    = btn_en;
  assign w_btn[BTN_SPEED] = btn_speed;
  assign w_btn[BTN_CLR]   = btn_clr;

  // Identical conditioning channel per button
  generate
    for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_chan
      debounce_onepulse #(
        .DB_DEPTH (DB_DEPTH)
      ) u_chan (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_tick  (w_tick),
        .i_btn   (w_btn[gi]),
        .o_db    (w_db[gi]),
        .o_pulse (w_pulse[gi])
      );
    end
  endgenerate

  // Only the enable level feeds the hold counter; the rest are pulse-only
  assign w_unused_db = ^w_db;

`ifdef BUTTON_CTRL_LONG_PRESS_EN
  localparam int                HOLD_W    = hold_bits(LONG_TICKS);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_TICKS);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_TICKS - 1);

  logic [HOLD_W-1:0] r_hold;
  logic              r_long;

  // Count ticks of continuous debounced hold, saturating so it fires once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold <= '0;
    end else if (!w_db[BTN_EN]) begin
      r_hold <= '0;
    end else if (w_tick && (r_hold < HOLD_MAX)) begin
      r_hold <= r_hold + 1'b1;
    end
  end

  // Pulse on the edge where the hold count reaches the threshold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_long <= 1'b0;
    end else begin
      r_long <= w_db[BTN_EN] & w_tick & (r_hold == HOLD_LAST);
    end
  end

  assign w_long = r_long;
`else
  logic w_unused_long;

  assign w_long        = 1'b0;
  assign w_unused_long = (LONG_TICKS > 0);
`endif

  // Toggle levels; a clear (or long press) wins and forces both low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en    <= 1'b0;
      r_speed <= 1'b0;
    end else if (w_pulse[BTN_CLR] || w_long) begin
      r_en    <= 1'b0;
      r_speed <= 1'b0;
    end else begin
      if (w_pulse[BTN_EN]) begin
        r_en <= ~r_en;
      end
      if (w_pulse[BTN_SPEED]) begin
        r_speed <= ~r_speed;
      end
    end
  end

  assign en          = r_en;
  assign speed       = r_speed;
  assign clr_pulse   = w_pulse[BTN_CLR];
  assign press_pulse = w_pulse;
  assign long_press  = w_long;

endmodule

// File: tb/tb_button_ctrl.sv
// Bench for button_ctrl with a fast tick (DIV_BITS=2, DB_DEPTH=4,
// LONG_TICKS=8). A behavioural model tracks sample run lengths per button
// and is compared against every DUT output on each falling edge; directed
// steps add literal expectations on pulse counts, levels and latency.
module tb_button_ctrl;

  localparam int DIVB = 2;
  localparam int DBD  = 4;
  localparam int LT   = 8;

  logic       clk;
  logic       rst_n;
  logic       btn_en;
  logic       btn_speed;
  logic       btn_clr;
  logic       en;
  logic       speed;
  logic       clr_pulse;
  logic [2:0] press_pulse;
  logic       long_press;

  int checks;
  int errors;
  int fail_prints;

  button_ctrl #(
    .DIV_BITS   (DIVB),
    .DB_DEPTH   (DBD),
    .LONG_TICKS (LT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_en      (btn_en),
    .btn_speed   (btn_speed),
    .btn_clr     (btn_clr),
    .en          (en),
    .speed       (speed),
    .clr_pulse   (clr_pulse),
    .press_pulse (press_pulse),
    .long_press  (long_press)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // Each button: the value seen at a tick is the raw level two edges earlier.
  // A level changes once DBD consecutive tick samples disagree with it.
  logic       m_en, m_speed, m_long;
  logic [2:0] m_pulse;
  logic [2:0] m_db;
  logic [2:0] m_prev1, m_prev2;
  logic [2:0] m_run_val;
  int         m_run_len [3];
  int         m_n;
  int         m_held;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_en = 0; m_speed = 0; m_long = 0; m_pulse = 0; m_db = 0;
      m_prev1 = 0; m_prev2 = 0; m_run_val = 0; m_n = 0; m_held = 0;
      for (int b = 0; b < 3; b++) m_run_len[b] = DBD;
    end else begin
      logic       tick;
      logic       old_db_en;
      logic [2:0] raw;
      raw = {btn_clr, btn_speed, btn_en};
      m_n++;
      if (m_pulse[2] || m_long) begin
        m_en = 0;
        m_speed = 0;
      end else begin
        if (m_pulse[0]) m_en = !m_en;
        if (m_pulse[1]) m_speed = !m_speed;
      end
      m_pulse = 0;
      m_long = 0;
      tick = ((m_n % (1 << DIVB)) == 0);
      old_db_en = m_db[0];
      if (tick) begin
        for (int b = 0; b < 3; b++) begin
          if (m_prev2[b] == m_run_val[b]) begin
            if (m_run_len[b] < DBD) m_run_len[b]++;
          end else begin
            m_run_val[b] = m_prev2[b];
            m_run_len[b] = 1;
          end
          if (m_run_len[b] >= DBD && m_run_val[b] != m_db[b]) begin
            m_db[b] = m_run_val[b];
            if (m_db[b]) m_pulse[b] = 1;
          end
        end
      end
`ifdef BUTTON_CTRL_LONG_PRESS_EN
      if (!old_db_en) m_held = 0;
      else if (tick && m_held < LT) begin
        m_held++;
        if (m_held == LT) m_long = 1;
      end
`else
      if (old_db_en && m_held < 0) m_held = 0;
`endif
      m_prev2 = m_prev1;
      m_prev1 = raw;
    end
  end

  // ---------------- per-cycle compare + DUT pulse counters ----------------
  int   cnt_pulse [3];
  int   cnt_long;
  logic seen_clr_speed;

  always @(negedge clk) begin
    logic [6:0] act, exp_v;
    act   = {en, speed, clr_pulse, press_pulse, long_press};
    exp_v = {m_en, m_speed, m_pulse[2], m_pulse, m_long};
    checks++;
    if (act !== exp_v) begin
      errors++;
      if (fail_prints < 20) begin
        fail_prints++;
        $display("FAIL cycle_model t=%0t: got {en,speed,clr,pp,long}=%b expected %b",
                 $time, act, exp_v);
      end
    end
    for (int b = 0; b < 3; b++) if (press_pulse[b] === 1'b1) cnt_pulse[b]++;
    if (long_press === 1'b1) cnt_long++;
    if (clr_pulse === 1'b1 && press_pulse[1] === 1'b1) seen_clr_speed = 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic clear_counts();
    for (int b = 0; b < 3; b++) cnt_pulse[b] = 0;
    cnt_long = 0;
    seen_clr_speed = 1'b0;
  endtask

  initial begin
    int edges;
    bit found;
    checks = 0; errors = 0; fail_prints = 0;
    btn_en = 0; btn_speed = 0; btn_clr = 0;
    clear_counts();

    // 1: reset
    rst_n = 0;
    cycles(3);
    check("reset_outputs", {27'd0, en, speed, clr_pulse, press_pulse[1:0], long_press}, 32'd0);
    rst_n = 1;
    cycles(10);
    check("idle_after_reset", {26'd0, en, speed, press_pulse, long_press}, 32'd0);
    $display("step 1 reset: en=%0b speed=%0b", en, speed);

    // 2: enable press / release twice
    clear_counts();
    btn_en = 1; cycles(40);
    btn_en = 0; cycles(40);
    check("en_press1_pulses", cnt_pulse[0], 1);
    check("en_after_press1", en, 1);
    clear_counts();
    btn_en = 1; cycles(40);
    btn_en = 0; cycles(40);
    check("en_press2_pulses", cnt_pulse[0], 1);
    check("en_after_press2", en, 0);
    $display("step 2 enable toggles: en=%0b", en);

    // 3: bouncing speed button, then steady
    clear_counts();
    for (int i = 0; i < 10; i++) begin
      btn_speed = ~btn_speed;
      cycles(3);
    end
    check("bounce_no_pulse", cnt_pulse[1], 0);
    btn_speed = 1; cycles(40);
    check("speed_steady_pulses", cnt_pulse[1], 1);
    check("speed_after_steady", speed, 1);
    btn_speed = 0; cycles(40);
    $display("step 3 bounce then steady: speed=%0b", speed);

    // 4: set en, then simultaneous clear + speed
    btn_en = 1; cycles(40);
    btn_en = 0; cycles(40);
    check("pre_clr_en_speed", {en, speed}, 2'b11);
    clear_counts();
    btn_clr = 1; btn_speed = 1; cycles(40);
    btn_clr = 0; btn_speed = 0; cycles(40);
    check("clr_speed_same_cycle", seen_clr_speed, 1);
    check("clr_pulses", cnt_pulse[2], 1);
    check("clr_forces_zero", {en, speed}, 2'b00);
    $display("step 4 simultaneous clr+speed: en=%0b speed=%0b", en, speed);

    // 5: reset during a held enable press
    btn_en = 1; cycles(8);
    rst_n = 0; cycles(2);
    check("mid_reset_outputs", {en, speed, press_pulse}, 5'd0);
    clear_counts();
    rst_n = 1;
    edges = 0; found = 0;
    for (int k = 0; k < 100 && !found; k++) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      #1;
      if (press_pulse[0] === 1'b1) found = 1;
    end
    check("held_press_found", found, 1);
    check("held_press_latency", edges, 16);
    cycles(40);
    check("held_press_pulses", cnt_pulse[0], 1);
    check("held_press_en", en, 1);
    btn_en = 0; cycles(40);
    $display("step 5 reset mid-press: latency=%0d en=%0b", edges, en);

    // 6: long hold of the enable button
    btn_clr = 1; cycles(40);
    btn_clr = 0; cycles(40);
    check("pre_long_en", en, 0);
    clear_counts();
    btn_en = 1; cycles(60);
    btn_en = 0; cycles(40);
    check("long_short_toggle", cnt_pulse[0], 1);
`ifdef BUTTON_CTRL_LONG_PRESS_EN
    check("long_pulses", cnt_long, 1);
    check("long_clears_en", en, 0);
`else
    check("long_pulses", cnt_long, 0);
    check("long_keeps_en", en, 1);
`endif
    $display("step 6 long hold: long_pulses=%0d en=%0b", cnt_long, en);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
